feed_servo_driver: RTL and testbench



---
 rtl/feed_servo_driver_pkg.sv | 30 +++
 rtl/feed_servo_driver_pwm_gen.sv | 40 ++++
 rtl/feed_servo_driver.sv | 149 ++++++++++++++
 tb/tb_feed_servo_driver.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feed_servo_driver_pkg.sv
// Shared types and constants for the feeder servo driver: FSM states,
// status codes written back to the CPU, and default timing values.
package feed_servo_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_CLOSE,
        ST_REPORT
    } state_e;

    localparam logic [31:0] DONE_OK    = 32'd1;
    localparam logic [31:0] DONE_ZERO  = 32'd2;
    localparam logic [31:0] DONE_ABORT = 32'd3;

    localparam logic [4:0] DONE_REG_IDX = 5'd27;

    localparam int DEF_PWM_PERIOD_CYCLES = 2_000_000;
    localparam int DEF_PULSE_OPEN        = 200_000;
    localparam int DEF_PULSE_CLOSED      = 100_000;
    localparam int DEF_TICK_CYCLES       = 100_000_000;
    localparam int DEF_SETTLE_FRAMES     = 25;
    localparam int DEF_MAX_DURATION      = 3600;

    function automatic logic [31:0] clamp_duration(input logic [31:0] value,
                                                   input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/feed_servo_driver_pwm_gen.sv
// Free-running servo frame generator. The pulse width is only taken from
// target_width at a frame boundary, so a pulse is never cut short.
module servo_pwm_gen #(
    parameter int PERIOD_CYCLES = 2_000_000,
    parameter int RESET_WIDTH   = 100_000,
    parameter int CNT_W         = $clog2(PERIOD_CYCLES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] target_width,
    output logic             motor_pwm,
    output logic             frame_wrap
);

    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] active_width_q, active_width_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        frame_wrap     = (frame_cnt_q == CNT_W'(PERIOD_CYCLES - 1));
        frame_cnt_d    = frame_wrap ? '0 : frame_cnt_q + 1'b1;
        active_width_d = frame_wrap ? target_width : active_width_q;
        pwm_d          = (frame_cnt_q < active_width_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_q    <= '0;
            active_width_q <= CNT_W'(RESET_WIDTH);
            pwm_q          <= 1'b0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            active_width_q <= active_width_d;
            pwm_q          <= pwm_d;
        end
    end

    assign motor_pwm = pwm_q;

endmodule

// File: rtl/feed_servo_driver.sv
// Feeder servo controller: accepts a feed on a rising feedReq edge, holds the
// servo open for the requested seconds, settles closed, then reports status.
module feed_servo_driver
    import feed_servo_driver_pkg::*;
#(
    parameter int PWM_PERIOD_CYCLES = DEF_PWM_PERIOD_CYCLES,
    parameter int PULSE_OPEN        = DEF_PULSE_OPEN,
    parameter int PULSE_CLOSED      = DEF_PULSE_CLOSED,
    parameter int TICK_CYCLES       = DEF_TICK_CYCLES,
    parameter int SETTLE_FRAMES     = DEF_SETTLE_FRAMES,
    parameter int MAX_DURATION      = DEF_MAX_DURATION,
    parameter int DONE_REG          = int'(DONE_REG_IDX)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        feedReq,
    input  logic [31:0] duration,
    input  logic        buttonWrite,
    output logic        motorPWM,
    output logic        busy,
    output logic        doneWrite,
    output logic [4:0]  doneReg,
    output logic [31:0] doneData
);

    localparam int PWM_W    = $clog2(PWM_PERIOD_CYCLES);
    localparam int TICK_W   = $clog2(TICK_CYCLES);
    localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

    state_e              state_q, state_d;
    logic                feed_req_q, feed_req_d;
    logic                armed_q, armed_d;
    logic [31:0]         remaining_q, remaining_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [31:0]         code_q, code_d;
    logic [31:0]         done_data_q, done_data_d;

    logic [PWM_W-1:0]    target_width;
    logic                frame_wrap;
    logic                feed_rise;
    logic [31:0]         latched;

    servo_pwm_gen #(
        .PERIOD_CYCLES (PWM_PERIOD_CYCLES),
        .RESET_WIDTH   (PULSE_CLOSED),
        .CNT_W         (PWM_W)
    ) u_pwm (
        .clock        (clock),
        .reset        (reset),
        .target_width (target_width),
        .motor_pwm    (motorPWM),
        .frame_wrap   (frame_wrap)
    );

    // armed_q blanks the first cycle after reset so a level already high at
    // release is not mistaken for a new request.
    always_comb begin
        state_d      = state_q;
        feed_req_d   = feedReq;
        armed_d      = 1'b1;
        remaining_d  = remaining_q;
        tick_d       = tick_q;
        settle_d     = settle_q;
        code_d       = code_q;
        done_data_d  = done_data_q;
        doneWrite    = 1'b0;
        feed_rise    = feedReq & ~feed_req_q & armed_q;
        latched      = clamp_duration(duration, 32'(MAX_DURATION));
        target_width = (state_q == ST_OPEN) ? PWM_W'(PULSE_OPEN) : PWM_W'(PULSE_CLOSED);

        case (state_q)
            ST_IDLE: begin
                if (feed_rise) begin
                    remaining_d = latched;
                    if (latched == 32'd0) begin
                        code_d  = DONE_ZERO;
                        state_d = ST_REPORT;
                    end else begin
                        tick_d  = '0;
                        state_d = ST_OPEN;
                    end
                end
            end
            ST_OPEN: begin
                if (!feedReq) begin
                    code_d   = DONE_ABORT;
                    settle_d = '0;
                    state_d  = ST_CLOSE;
                end else if (tick_q == TICK_W'(TICK_CYCLES - 1)) begin
                    tick_d      = '0;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        code_d   = DONE_OK;
                        settle_d = '0;
                        state_d  = ST_CLOSE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_CLOSE: begin
                if (frame_wrap) begin
                    if (settle_q == SETTLE_W'(SETTLE_FRAMES - 1)) begin
                        state_d = ST_REPORT;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                // The button controller always owns the write port first.
                if (!buttonWrite && !reset) begin
                    doneWrite   = 1'b1;
                    done_data_d = code_q;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            feed_req_q  <= 1'b0;
            armed_q     <= 1'b0;
            remaining_q <= '0;
            tick_q      <= '0;
            settle_q    <= '0;
            code_q      <= '0;
            done_data_q <= '0;
        end else begin
            state_q     <= state_d;
            feed_req_q  <= feed_req_d;
            armed_q     <= armed_d;
            remaining_q <= remaining_d;
            tick_q      <= tick_d;
            settle_q    <= settle_d;
            code_q      <= code_d;
            done_data_q <= done_data_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign doneReg  = 5'(DONE_REG);
    assign doneData = doneWrite ? code_q : done_data_q;

endmodule

// File: tb/tb_feed_servo_driver.sv
// Scenario bench for feed_servo_driver with shortened timing; expected status
// codes are queued when a feed is requested and popped when doneWrite fires.
module tb_feed_servo_driver;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        feedReq = 1'b0;
    logic [31:0] duration = 32'd0;
    logic        buttonWrite = 1'b0;
    logic        motorPWM;
    logic        busy;
    logic        doneWrite;
    logic [4:0]  doneReg;
    logic [31:0] doneData;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    int done_count = 0;
    bit collision = 0;
    int run_len = 0;
    int open_runs = 0;
    int closed_runs = 0;
    int odd_runs = 0;
    int closed_since_open = 0;

    always #5 clock = ~clock;

    feed_servo_driver #(
        .PWM_PERIOD_CYCLES (100),
        .PULSE_OPEN        (20),
        .PULSE_CLOSED      (10),
        .TICK_CYCLES       (200),
        .SETTLE_FRAMES     (2),
        .MAX_DURATION      (3600)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .feedReq     (feedReq),
        .duration    (duration),
        .buttonWrite (buttonWrite),
        .motorPWM    (motorPWM),
        .busy        (busy),
        .doneWrite   (doneWrite),
        .doneReg     (doneReg),
        .doneData    (doneData)
    );

    // Passive monitor: counts status writes and classifies completed PWM pulses.
    always @(posedge clock) begin
        if (doneWrite === 1'b1) done_count++;
        if (doneWrite === 1'b1 && buttonWrite === 1'b1) collision = 1;
        if (reset) begin
            run_len = 0;
        end else if (motorPWM === 1'b1) begin
            run_len++;
        end else if (run_len != 0) begin
            if (run_len == 20) begin
                open_runs++;
                closed_since_open = 0;
            end else if (run_len == 10) begin
                closed_runs++;
                closed_since_open++;
            end else begin
                odd_runs++;
            end
            run_len = 0;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (doneWrite === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        feedReq = 1'b1;
        repeat (3) next_cycle();
        @(negedge clock);
        checks++;
        if (motorPWM !== 1'b0) begin failures++; $display("[TB] FAIL reset_pwm actual=%b required=0", motorPWM); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
        checks++;
        if (doneWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_donewrite actual=%b required=0", doneWrite); end
        checks++;
        if (doneData !== 32'd0) begin failures++; $display("[TB] FAIL reset_donedata actual=%0d required=0", doneData); end
        checks++;
        if (doneReg !== 5'd27) begin failures++; $display("[TB] FAIL reset_donereg actual=%0d required=27", doneReg); end
        next_cycle();
        reset = 1'b0;
        repeat (5) next_cycle();
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL high_at_release_busy actual=%b required=0", busy); end
        next_cycle();
        feedReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_idle();
        int high = 0;
        int bad_busy = 0;
        int d0 = done_count;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (motorPWM === 1'b1) high++;
            if (busy !== 1'b0) bad_busy++;
        end
        next_cycle();
        checks++;
        if (high != 30) begin failures++; $display("[TB] FAIL idle_pwm_high actual=%0d required=30", high); end
        checks++;
        if (bad_busy != 0) begin failures++; $display("[TB] FAIL idle_busy actual=%0d required=0", bad_busy); end
        checks++;
        if (done_count != d0) begin failures++; $display("[TB] FAIL idle_donewrite actual=%0d required=0", done_count - d0); end
    endtask

    task automatic test_open_complete();
        bit seen;
        int exp;
        int o0 = open_runs;
        int odd0 = odd_runs;
        duration = 32'd3;
        next_cycle();
        feedReq = 1'b1;
        exp_q.push_back(1);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_before_accept actual=%b required=0", busy); end
        next_cycle();
        duration = 32'd0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_after_accept actual=%b required=1", busy); end
        wait_done(2000, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL open_done_seen actual=none required=doneWrite");
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL open_done_data actual=%0d required=%0d", doneData, exp); end
            checks++;
            if (doneReg !== 5'd27) begin failures++; $display("[TB] FAIL open_done_reg actual=%0d required=27", doneReg); end
            checks++;
            if (closed_since_open < 1) begin failures++; $display("[TB] FAIL open_settle_pulses actual=%0d required>=1", closed_since_open); end
        end
        checks++;
        if (open_runs - o0 != 6) begin failures++; $display("[TB] FAIL open_pulse_count actual=%0d required=6", open_runs - o0); end
        checks++;
        if (odd_runs != odd0) begin failures++; $display("[TB] FAIL open_truncated_pulses actual=%0d required=0", odd_runs - odd0); end
        next_cycle();
        @(negedge clock);
        checks++;
        if (doneWrite !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL open_after_report actual=dw%b_busy%b required=dw0_busy0", doneWrite, busy);
        end
        next_cycle();
        feedReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero();
        bit seen;
        int exp;
        int o0 = open_runs;
        duration = 32'd0;
        next_cycle();
        feedReq = 1'b1;
        exp_q.push_back(2);
        wait_done(3, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL zero_done_seen actual=none required=doneWrite_within_3");
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL zero_done_data actual=%0d required=%0d", doneData, exp); end
        end
        repeat (200) next_cycle();
        checks++;
        if (open_runs != o0) begin failures++; $display("[TB] FAIL zero_open_pulses actual=%0d required=0", open_runs - o0); end
        feedReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_abort();
        bit seen;
        int exp;
        int o0 = open_runs;
        duration = 32'd5;
        next_cycle();
        feedReq = 1'b1;
        exp_q.push_back(3);
        repeat (250) next_cycle();
        feedReq = 1'b0;
        wait_done(1000, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL abort_done_seen actual=none required=doneWrite");
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL abort_done_data actual=%0d required=%0d", doneData, exp); end
        end
        checks++;
        if (open_runs - o0 < 2 || open_runs - o0 > 3) begin
            failures++; $display("[TB] FAIL abort_open_pulses actual=%0d required=2..3", open_runs - o0);
        end
        next_cycle();
    endtask

    task automatic test_button_priority();
        int exp;
        int bad = 0;
        duration = 32'd0;
        next_cycle();
        feedReq = 1'b1;
        buttonWrite = 1'b1;
        exp_q.push_back(2);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            @(negedge clock);
            if (doneWrite !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("[TB] FAIL button_suppress actual=%0d required=0", bad); end
        next_cycle();
        buttonWrite = 1'b0;
        @(negedge clock);
        exp = exp_q.pop_front();
        checks++;
        if (doneWrite !== 1'b1) begin
            failures++; $display("[TB] FAIL button_release_write actual=%b required=1", doneWrite);
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL button_done_data actual=%0d required=%0d", doneData, exp); end
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (doneWrite !== 1'b0) begin failures++; $display("[TB] FAIL button_one_cycle actual=%b required=0", doneWrite); end
        checks++;
        if (collision) begin failures++; $display("[TB] FAIL button_collision actual=1 required=0"); end
        feedReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_open();
        int d0, o0, c0;
        int bad_busy = 0;
        duration = 32'd5;
        next_cycle();
        feedReq = 1'b1;
        repeat (300) next_cycle();
        reset = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;
        d0 = done_count;
        o0 = open_runs;
        c0 = closed_runs;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (busy !== 1'b0) bad_busy++;
        end
        next_cycle();
        checks++;
        if (done_count != d0) begin failures++; $display("[TB] FAIL midreset_donewrite actual=%0d required=0", done_count - d0); end
        checks++;
        if (open_runs != o0) begin failures++; $display("[TB] FAIL midreset_open_pulses actual=%0d required=0", open_runs - o0); end
        checks++;
        if (closed_runs - c0 < 3) begin failures++; $display("[TB] FAIL midreset_closed_pulses actual=%0d required>=3", closed_runs - c0); end
        checks++;
        if (bad_busy != 0) begin failures++; $display("[TB] FAIL midreset_busy actual=%0d required=0", bad_busy); end
        feedReq = 1'b0;
        next_cycle();
    endtask

    task automatic test_held_high();
        bit seen;
        int exp;
        int d0;
        int bad_busy = 0;
        int o0 = open_runs;
        duration = 32'd1;
        next_cycle();
        feedReq = 1'b1;
        exp_q.push_back(1);
        wait_done(1000, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL held_done_seen actual=none required=doneWrite");
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL held_done_data actual=%0d required=%0d", doneData, exp); end
        end
        checks++;
        if (open_runs - o0 != 2) begin failures++; $display("[TB] FAIL held_open_pulses actual=%0d required=2", open_runs - o0); end
        next_cycle();
        d0 = done_count;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (busy !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_busy != 0 || done_count != d0) begin
            failures++; $display("[TB] FAIL held_no_retrigger actual=busy%0d_writes%0d required=0_0", bad_busy, done_count - d0);
        end
        next_cycle();
        feedReq = 1'b0;
        next_cycle();
        feedReq = 1'b1;
        exp_q.push_back(1);
        next_cycle();
        @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rearm_busy actual=%b required=1", busy); end
        wait_done(1000, seen);
        exp = exp_q.pop_front();
        checks++;
        if (!seen) begin
            failures++; $display("[TB] FAIL rearm_done_seen actual=none required=doneWrite");
        end else begin
            checks++;
            if (doneData !== 32'(exp)) begin failures++; $display("[TB] FAIL rearm_done_data actual=%0d required=%0d", doneData, exp); end
        end
        next_cycle();
        feedReq = 1'b0;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_idle();
        test_open_complete();
        test_zero();
        test_abort();
        test_button_priority();
        test_reset_mid_open();
        test_held_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
